change_dispenser: RTL and testbench
===================================

# change_dispenser

Pays out a change amount as a sequence of individual coins, the inverse of coin detection: where the coin detector turns an inserted coin code into a value, this block turns a value back into coin codes. It sits between the vending controller's change output and the coin-hopper driver, and tracks per-denomination coin inventory. It uses a greedy, largest-coin-first algorithm with fallback to smaller coins when a tube is empty.

## Interface
- INV_INIT, 8'd20, coin count loaded into every tube at reset and on refill
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to pay change_amount; accepted only in IDLE
- change_amount  in  8  amount to pay in units; sampled on an accepted start
- refill  in  1  loads INV_INIT into all three tubes; accepted only in IDLE
- coin_ready  in  1  hopper accepts the presented coin this cycle
- coin_valid  out  1  a coin is presented on coin_code
- coin_code  out  4  coin to eject: 4'd3 = 10 units, 4'd2 = 5 units, 4'd1 = 1 unit, 4'd0 = none
- remaining  out  8  amount still unpaid
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse when a payout ends, whether complete or short
- short  out  1  payout ended with remaining > 0; held until the next accepted start or reset
- inv_hi, inv_mid, inv_lo  out  8 each  coins left in the 10-, 5- and 1-unit tubes

## Operation
- States: IDLE, SELECT, PAY. Encoding is free.
- IDLE, start=1:
  - latch remaining <= change_amount
  - clear short
  - go to SELECT
- SELECT, picks the first matching rule in this order:
  - 10 ≤ remaining and inv_hi > 0: code 3
  - 5 ≤ remaining and inv_mid > 0: code 2
  - 1 ≤ remaining and inv_lo > 0: code 1
  - If a coin is picked: register coin_code and go to PAY.
  - If remaining == 0: pulse done and go to IDLE.
  - Otherwise (remaining > 0, no coin available): set short, pulse done, go to IDLE.
- PAY:
  - coin_valid=1; coin_code is held stable.
  - On coin_valid & coin_ready: subtract the coin value from remaining, decrement the matching tube, set coin_code <= 0, go to SELECT.
  - Without coin_ready: hold all outputs, with no timeout.
- Width rules:
  - remaining never underflows, because a coin is selected only when its value ≤ remaining.
  - Tubes never go below 0, because a coin is selected only when its tube > 0.
  - There is no wrap-around.
- refill in IDLE sets all tubes to INV_INIT on the next edge.
- Simultaneous refill and start in IDLE: both are accepted. SELECT sees the refilled counts.
- start or refill while busy is ignored, with no queuing. change_amount changes while busy have no effect.
- Reset values:
  - state IDLE, coin_valid 0, coin_code 0, remaining 0
  - busy 0, done 0, short 0
  - inv_hi = inv_mid = inv_lo = INV_INIT
- Reset mid-payout aborts immediately: coin_valid drops asynchronously and no done pulse is produced.

## Timing
- start sampled at edge N: state is SELECT and busy=1 after edge N.
- The first coin_valid is high after edge N+1.
- Handshake at edge M: coin_valid=0 after M and remaining/inventory are updated after M. The next coin_valid is high after M+1. With coin_ready held at 1, there is one coin every 2 cycles.
- Completion from SELECT at edge K: done=1 and busy=0 for the cycle after K.
- change_amount=0: done pulses in the cycle after edge N+1.
- All outputs are registered. coin_valid does not depend combinationally on coin_ready.

## Test plan
- Reset, start with change_amount=27, coin_ready tied to 1. Required:
  - codes 3,3,2,1,1, one every 2 cycles
  - remaining 27→17→7→2→1→0
  - done pulse, short=0
  - inv_hi=18, inv_mid=19, inv_lo=18
- start with change_amount=0. Required: coin_valid never rises; done pulses 2 cycles after start; short=0; inventories unchanged.
- Backpressure: change_amount=10, coin_ready low for 5 cycles after coin_valid rises. Required: coin_valid=1 and coin_code=3 stable throughout; remaining stays 10 until ready; then remaining=0 and inv_hi decrements by exactly 1.
- INV_INIT=1, change_amount=23. Required: codes 3,2,1; then short=1 with a done pulse; remaining=7; all tubes 0. A following refill restores all tubes to 1.
- While busy, pulse start with change_amount=99 and pulse refill. Required: both are ignored; the payout finishes with the original amount and inventories.
- Assert rst_n low while in PAY with coin_valid=1. Required: coin_valid=0 immediately; all outputs at reset values; no done pulse. A new start after release pays normally.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vending controller/coin hopper and the change dispenser.
interface change_dispenser_if;
  logic       start;
  logic [7:0] change_amount;
  logic       refill;
  logic       coin_ready;
  logic       coin_valid;
  logic [3:0] coin_code;
  logic [7:0] remaining;
  logic       busy;
  logic       done;
  logic       short;
  logic [7:0] inv_hi;
  logic [7:0] inv_mid;
  logic [7:0] inv_lo;

  modport master (
    output start, change_amount, refill, coin_ready,
    input  coin_valid, coin_code, remaining, busy, done, short, inv_hi, inv_mid, inv_lo
  );

  modport slave (
    input  start, change_amount, refill, coin_ready,
    output coin_valid, coin_code, remaining, busy, done, short, inv_hi, inv_mid, inv_lo
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: turns an amount into a stream of coin codes, largest coin first,
// falling back to smaller coins when a tube runs empty, and tracks per-tube inventory.
module change_dispenser #(
  parameter logic [7:0] INV_INIT = 8'd20
) (
  input logic               clk,
  input logic               rst_n,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    PAY    = 2'd2
  } state_t;

  localparam logic [3:0] CODE_NONE = 4'd0;
  localparam logic [3:0] CODE_LO   = 4'd1;
  localparam logic [3:0] CODE_MID  = 4'd2;
  localparam logic [3:0] CODE_HI   = 4'd3;

  function automatic logic [7:0] coin_value(input logic [3:0] code);
    case (code)
      CODE_HI:  coin_value = 8'd10;
      CODE_MID: coin_value = 8'd5;
      CODE_LO:  coin_value = 8'd1;
      default:  coin_value = 8'd0;
    endcase
  endfunction

  state_t     state_r, state_s;
  logic [7:0] remaining_r, remaining_s;
  logic [3:0] code_r, code_s;
  logic       valid_r, valid_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       short_r, short_s;
  logic [7:0] hi_r, hi_s;
  logic [7:0] mid_r, mid_s;
  logic [7:0] lo_r, lo_s;

  // Next-state and next-output logic for the payout sequencer
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    code_s      = code_r;
    done_s      = 1'b0;
    short_s     = short_r;
    hi_s        = hi_r;
    mid_s       = mid_r;
    lo_s        = lo_r;

    case (state_r)
      IDLE: begin
        // Refill and start may land together; SELECT then sees the refilled tubes.
        if (bus.refill) begin
          hi_s  = INV_INIT;
          mid_s = INV_INIT;
          lo_s  = INV_INIT;
        end else begin
          hi_s  = hi_r;
          mid_s = mid_r;
          lo_s  = lo_r;
        end
        if (bus.start) begin
          remaining_s = bus.change_amount;
          short_s     = 1'b0;
          state_s     = SELECT;
        end else begin
          state_s = IDLE;
        end
      end
      SELECT: begin
        if (remaining_r >= 8'd10 && hi_r != 8'd0) begin
          code_s  = CODE_HI;
          state_s = PAY;
        end else if (remaining_r >= 8'd5 && mid_r != 8'd0) begin
          code_s  = CODE_MID;
          state_s = PAY;
        end else if (remaining_r >= 8'd1 && lo_r != 8'd0) begin
          code_s  = CODE_LO;
          state_s = PAY;
        end else if (remaining_r == 8'd0) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          short_s = 1'b1;
          done_s  = 1'b1;
          state_s = IDLE;
        end
      end
      PAY: begin
        // Selection guarantees value <= remaining and tube > 0, so neither can wrap.
        if (bus.coin_ready) begin
          remaining_s = remaining_r - coin_value(code_r);
          case (code_r)
            CODE_HI:  hi_s  = hi_r  - 8'd1;
            CODE_MID: mid_s = mid_r - 8'd1;
            CODE_LO:  lo_s  = lo_r  - 8'd1;
            default:  hi_s  = hi_r;
          endcase
          code_s  = CODE_NONE;
          state_s = SELECT;
        end else begin
          state_s = PAY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    valid_s = (state_s == PAY);
    busy_s  = (state_s != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs and inventory counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_r <= 8'd0;
      code_r      <= CODE_NONE;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      short_r     <= 1'b0;
      hi_r        <= INV_INIT;
      mid_r       <= INV_INIT;
      lo_r        <= INV_INIT;
    end else begin
      remaining_r <= remaining_s;
      code_r      <= code_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      short_r     <= short_s;
      hi_r        <= hi_s;
      mid_r       <= mid_s;
      lo_r        <= lo_s;
    end
  end

  assign bus.coin_valid = valid_r;
  assign bus.coin_code  = code_r;
  assign bus.remaining  = remaining_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.short      = short_r;
  assign bus.inv_hi     = hi_r;
  assign bus.inv_mid    = mid_r;
  assign bus.inv_lo     = lo_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a greedy model fills a coin scoreboard at start,
// entries are popped and compared as the hopper handshakes each coin.
module tb_change_dispenser;

  logic       clk;
  logic       rst_n;
  logic       sel;
  logic       start_d;
  logic [7:0] amt_d;
  logic       refill_d;
  logic       ready_d;

  change_dispenser_if bus_a();
  change_dispenser_if bus_b();

  change_dispenser #(.INV_INIT(8'd20)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  change_dispenser #(.INV_INIT(8'd1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  assign bus_a.start         = start_d & ~sel;
  assign bus_a.refill        = refill_d & ~sel;
  assign bus_a.change_amount = amt_d;
  assign bus_a.coin_ready    = ready_d;
  assign bus_b.start         = start_d & sel;
  assign bus_b.refill        = refill_d & sel;
  assign bus_b.change_amount = amt_d;
  assign bus_b.coin_ready    = ready_d;

  logic       valid_o, busy_o, done_o, short_o;
  logic [3:0] code_o;
  logic [7:0] rem_o, hi_o, mid_o, lo_o;
  assign valid_o = sel ? bus_b.coin_valid : bus_a.coin_valid;
  assign code_o  = sel ? bus_b.coin_code  : bus_a.coin_code;
  assign rem_o   = sel ? bus_b.remaining  : bus_a.remaining;
  assign busy_o  = sel ? bus_b.busy       : bus_a.busy;
  assign done_o  = sel ? bus_b.done       : bus_a.done;
  assign short_o = sel ? bus_b.short      : bus_a.short;
  assign hi_o    = sel ? bus_b.inv_hi     : bus_a.inv_hi;
  assign mid_o   = sel ? bus_b.inv_mid    : bus_a.inv_mid;
  assign lo_o    = sel ? bus_b.inv_lo     : bus_a.inv_lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] code_q[$];
  logic [7:0] rem_q[$];
  int ha, ma, la;
  int hb, mb, lb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic plan(input int amt, inout int hi, inout int mid, inout int lo,
                      output int left, output bit sh);
    int r;
    r = amt;
    code_q.delete();
    rem_q.delete();
    while (1) begin
      if (r >= 10 && hi > 0) begin
        r -= 10; hi--; code_q.push_back(4'd3); rem_q.push_back(r[7:0]);
      end else if (r >= 5 && mid > 0) begin
        r -= 5; mid--; code_q.push_back(4'd2); rem_q.push_back(r[7:0]);
      end else if (r >= 1 && lo > 0) begin
        r -= 1; lo--; code_q.push_back(4'd1); rem_q.push_back(r[7:0]);
      end else begin
        break;
      end
    end
    left = r;
    sh   = (r != 0);
  endtask

  task automatic run(input logic [7:0] amt, input int stall, input bit junk);
    int cyc, prev, left, stall_left, rem_now;
    bit sh, got_done, have_prev;
    logic [3:0] ec;
    logic [7:0] er;
    if (sel) plan(int'(amt), hb, mb, lb, left, sh);
    else     plan(int'(amt), ha, ma, la, left, sh);
    rem_now    = int'(amt);
    stall_left = stall;
    @(negedge clk);
    start_d = 1'b1;
    amt_d   = amt;
    @(negedge clk);
    start_d = 1'b0;
    check("busy_after_start", busy_o, 1);
    check("select_no_valid", valid_o, 0);
    if (junk) begin
      start_d  = 1'b1;
      amt_d    = 8'd99;
      refill_d = 1'b1;
    end
    @(negedge clk);
    start_d  = 1'b0;
    refill_d = 1'b0;
    if (code_q.size() > 0) check("first_valid", valid_o, 1);
    else                   check("zero_amount_done", done_o, 1);
    cyc = 0; prev = 0; got_done = 0; have_prev = 0;
    while (!got_done && cyc < 400) begin
      if (done_o) begin
        got_done = 1;
      end else if (valid_o && stall_left > 0) begin
        ready_d = 1'b0;
        stall_left--;
        check("stall_code", code_o, code_q.size() > 0 ? code_q[0] : 4'd0);
        check("stall_remaining", rem_o, rem_now);
        @(negedge clk); cyc++;
        check("stall_valid_held", valid_o, 1);
      end else if (valid_o) begin
        ready_d = 1'b1;
        if (code_q.size() == 0) begin
          check("extra_coin", valid_o, 0);
          cyc = 400;
        end else begin
          ec = code_q.pop_front();
          er = rem_q.pop_front();
          check("coin_code", code_o, ec);
          if (have_prev && stall == 0) check("coin_gap", cyc - prev, 2);
          have_prev = 1;
          prev      = cyc;
          @(negedge clk); cyc++;
          check("valid_drop", valid_o, 0);
          check("remaining", rem_o, er);
          rem_now = int'(er);
        end
      end else begin
        @(negedge clk); cyc++;
      end
    end
    check("done_seen", got_done, 1);
    check("coins_outstanding", code_q.size(), 0);
    check("final_short", short_o, sh);
    check("final_remaining", rem_o, left);
    check("final_busy", busy_o, 0);
    check("inv_hi", hi_o,  sel ? hb : ha);
    check("inv_mid", mid_o, sel ? mb : ma);
    check("inv_lo", lo_o,  sel ? lb : la);
    @(negedge clk);
    check("done_one_cycle", done_o, 0);
    check("short_held", short_o, sh);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; start_d = 1'b0; amt_d = 8'd0; refill_d = 1'b0; ready_d = 1'b1;
    ha = 20; ma = 20; la = 20;
    hb = 1;  mb = 1;  lb = 1;
    #12;
    check("rst_valid", valid_o, 0);
    check("rst_code", code_o, 0);
    check("rst_remaining", rem_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_short", short_o, 0);
    check("rst_inv_hi", hi_o, 20);
    check("rst_inv_mid", mid_o, 20);
    check("rst_inv_lo", lo_o, 20);
    @(negedge clk);
    rst_n = 1'b1;

    // 27 with ready tied high: 3,3,2,1,1
    run(8'd27, 0, 1'b0);
    check("t1_inv_hi_abs", hi_o, 18);
    check("t1_inv_mid_abs", mid_o, 19);
    check("t1_inv_lo_abs", lo_o, 18);

    // zero amount: no coin, done two cycles after start
    run(8'd0, 0, 1'b0);

    // backpressure on a single 10-unit coin
    ready_d = 1'b0;
    run(8'd10, 5, 1'b0);
    check("bp_inv_hi_abs", hi_o, 17);
    ready_d = 1'b1;

    // start/refill while busy are ignored
    run(8'd16, 0, 1'b1);
    check("busy_refill_ignored", hi_o, 16);

    // tubes of one coin each: short payout, then refill
    sel = 1'b1;
    run(8'd23, 0, 1'b0);
    check("short_rem_abs", rem_o, 7);
    @(negedge clk);
    refill_d = 1'b1;
    @(negedge clk);
    refill_d = 1'b0;
    hb = 1; mb = 1; lb = 1;
    check("refill_hi", hi_o, 1);
    check("refill_mid", mid_o, 1);
    check("refill_lo", lo_o, 1);
    check("refill_short_kept", short_o, 1);
    sel = 1'b0;

    // reset while a coin is presented
    ready_d = 1'b0;
    @(negedge clk);
    start_d = 1'b1; amt_d = 8'd30;
    @(negedge clk);
    start_d = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", valid_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid_drop", valid_o, 0);
    check("async_code", code_o, 0);
    check("async_remaining", rem_o, 0);
    check("async_busy", busy_o, 0);
    check("async_inv_hi", hi_o, 20);
    check("async_inv_mid", mid_o, 20);
    check("async_inv_lo", lo_o, 20);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("no_done_in_reset", done_o, 0);
    end
    rst_n = 1'b1;
    ready_d = 1'b1;
    ha = 20; ma = 20; la = 20;
    hb = 1;  mb = 1;  lb = 1;
    check("post_reset_done", done_o, 0);
    run(8'd27, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
